// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg
// Shared types and constants for the pipeline stall/flush controller.
//   - HZ_ASIZE   : default register-file address width
//   - HZ_WAIT_W  : width of the memory wait counter (covers timeouts up to 255)
//   - hz_state_e : controller states (RUN, MEM_WAIT, ERROR)
//   - hz_ctrl_t  : bundle of per-stage enables and flushes
//   - hz_ctrl_*  : canned control patterns for each pipeline situation
package pipeline_hazard_ctrl_pkg;

  localparam int HZ_ASIZE  = 5;
  localparam int HZ_WAIT_W = 8;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_MEM_WAIT = 2'd1,
    HZ_ERROR    = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic pcEn;
    logic ifidEn;
    logic idexEn;
    logic exmemEn;
    logic memwbEn;
    logic ifidFlush;
    logic idexFlush;
    logic exmemFlush;
    logic memwbFlush;
  } hz_ctrl_t;

  // Normal flow: every stage advances, nothing is squashed.
  function automatic hz_ctrl_t hz_ctrl_default();
    hz_ctrl_t c;
    c = '0;
    c.pcEn    = 1'b1;
    c.ifidEn  = 1'b1;
    c.idexEn  = 1'b1;
    c.exmemEn = 1'b1;
    c.memwbEn = 1'b1;
    return c;
  endfunction

  // Reset: everything held and every pipeline register cleared.
  function automatic hz_ctrl_t hz_ctrl_reset();
    hz_ctrl_t c;
    c = '0;
    c.ifidFlush  = 1'b1;
    c.idexFlush  = 1'b1;
    c.exmemFlush = 1'b1;
    c.memwbFlush = 1'b1;
    return c;
  endfunction

  // Memory stall: freeze PC through EX/MEM and feed a bubble into MEM/WB.
  function automatic hz_ctrl_t hz_ctrl_mem_stall();
    hz_ctrl_t c;
    c = '0;
    c.memwbEn    = 1'b1;
    c.memwbFlush = 1'b1;
    return c;
  endfunction

  // Redirect: fetch from the new target and squash the two wrong-path slots.
  function automatic hz_ctrl_t hz_ctrl_redirect();
    hz_ctrl_t c;
    c = hz_ctrl_default();
    c.ifidFlush = 1'b1;
    c.idexFlush = 1'b1;
    return c;
  endfunction

  // Load-use: hold fetch/decode one cycle and put a bubble into EX.
  function automatic hz_ctrl_t hz_ctrl_load_use();
    hz_ctrl_t c;
    c = hz_ctrl_default();
    c.pcEn      = 1'b0;
    c.ifidEn    = 1'b0;
    c.idexFlush = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// pipeline_hazard_ctrl_sat_counter
// Saturating event counter: counts cycles with inc_i high and sticks at all-ones.
// Ports:
//   clk     : clock
//   rst     : synchronous, active-high reset (count -> 0)
//   inc_i   : increment request for this cycle
//   count_o : current count
module pipeline_hazard_ctrl_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  // Stop at all-ones so long runs never wrap back to small values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central stall/flush controller for the 5-stage pipeline. Enables hold a pipeline
// register when 0; flushes load zeros and win over the enable.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   id_rs_addr_i, id_rt_addr_i    : ID-stage source registers
//   id_uses_rs_i, id_uses_rt_i    : ID instruction actually reads rs / rt
//   ex_waddr_i, ex_wen_i          : EX-stage destination and write enable
//   ex_memtoreg_i                 : EX instruction is a load
//   ex_redirect_i                 : taken branch / jump resolved in EX
//   mem_req_i, mem_ready_i        : data-memory handshake of the MEM stage
//   *_en_o, *_flush_o             : per-stage enables and bubble inserts
//   hz_err_o                      : memory timeout, sticky until rst
//   stall_cycles_o, flush_events_o: saturating performance counters
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int ASIZE       = HZ_ASIZE,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ASIZE-1:0] id_rs_addr_i,
  input  logic [ASIZE-1:0] id_rt_addr_i,
  input  logic             id_uses_rs_i,
  input  logic             id_uses_rt_i,
  input  logic [ASIZE-1:0] ex_waddr_i,
  input  logic             ex_wen_i,
  input  logic             ex_memtoreg_i,
  input  logic             ex_redirect_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  output logic             pc_en_o,
  output logic             ifid_en_o,
  output logic             idex_en_o,
  output logic             exmem_en_o,
  output logic             memwb_en_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             exmem_flush_o,
  output logic             memwb_flush_o,
  output logic             hz_err_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_events_o
);

  hz_state_e              state_q;
  logic [HZ_WAIT_W-1:0]   wait_cnt_q;
  logic                   hz_err_q;

  logic                   loadUse;
  logic                   memStall;
  hz_ctrl_t               ctrl;
  logic                   stallInc;
  logic                   flushInc;

  // A load in EX whose destination feeds the ID instruction needs one bubble;
  // register 0 is hard-wired so it never counts as a dependency.
  always_comb begin
    loadUse = ex_memtoreg_i && ex_wen_i && (ex_waddr_i != '0) &&
              ((id_uses_rs_i && (id_rs_addr_i == ex_waddr_i)) ||
               (id_uses_rt_i && (id_rt_addr_i == ex_waddr_i)));
  end

  // A dropped mem_req while waiting naturally falls out as "no stall", which
  // releases the pipeline exactly like mem_ready would.
  always_comb begin
    memStall = 1'b0;
    if (state_q != HZ_ERROR) begin
      memStall = mem_req_i && !mem_ready_i;
    end
  end

  // Priority mux: reset, then error freeze, then memory stall > redirect > load-use.
  always_comb begin
    ctrl = hz_ctrl_default();
    if (rst) begin
      ctrl = hz_ctrl_reset();
    end else if (state_q == HZ_ERROR) begin
      ctrl = '0;
    end else if (memStall) begin
      ctrl = hz_ctrl_mem_stall();
    end else if (ex_redirect_i) begin
      ctrl = hz_ctrl_redirect();
    end else if (loadUse) begin
      ctrl = hz_ctrl_load_use();
    end
  end

  // Controller FSM. wait_cnt counts stalled cycles already spent; once it has
  // reached the timeout and memory still is not ready, the pipeline is frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HZ_RUN;
      wait_cnt_q <= '0;
      hz_err_q   <= 1'b0;
    end else begin
      case (state_q)
        HZ_RUN: begin
          if (memStall) begin
            state_q    <= HZ_MEM_WAIT;
            wait_cnt_q <= HZ_WAIT_W'(1);
          end
        end
        HZ_MEM_WAIT: begin
          if (!memStall) begin
            state_q    <= HZ_RUN;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q == HZ_WAIT_W'(MEM_TIMEOUT)) begin
            state_q  <= HZ_ERROR;
            hz_err_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + HZ_WAIT_W'(1);
          end
        end
        HZ_ERROR: begin
          hz_err_q <= 1'b1;
        end
        default: begin
          state_q    <= HZ_RUN;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

  // Stalls frozen by ERROR are not counted; counters clear on rst anyway.
  assign stallInc = !rst && (state_q != HZ_ERROR) && !ctrl.pcEn;
  assign flushInc = !rst && ctrl.ifidFlush;

  pipeline_hazard_ctrl_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (stallInc),
    .count_o (stall_cycles_o)
  );

  pipeline_hazard_ctrl_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (flushInc),
    .count_o (flush_events_o)
  );

  assign pc_en_o       = ctrl.pcEn;
  assign ifid_en_o     = ctrl.ifidEn;
  assign idex_en_o     = ctrl.idexEn;
  assign exmem_en_o    = ctrl.exmemEn;
  assign memwb_en_o    = ctrl.memwbEn;
  assign ifid_flush_o  = ctrl.ifidFlush;
  assign idex_flush_o  = ctrl.idexFlush;
  assign exmem_flush_o = ctrl.exmemFlush;
  assign memwb_flush_o = ctrl.memwbFlush;
  assign hz_err_o      = hz_err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
// Scoreboard bench for pipeline_hazard_ctrl: the stimulus process drives one input
// vector per cycle and pushes the reference model's expected outputs; the monitor
// pops and compares mid-cycle. Small MEM_TIMEOUT/CNT_W make timeout and counter
// saturation reachable.
module tb_pipeline_hazard_ctrl;

  localparam int ASIZE   = 5;
  localparam int TIMEOUT = 4;
  localparam int CW      = 4;
  localparam int CMAX    = (1 << CW) - 1;

  logic             clk;
  logic             rst;
  logic [ASIZE-1:0] idRs, idRt, exWaddr;
  logic             useRs, useRt, exWen, exM2r, exRedir, memReq, memRdy;
  logic             pcEn, ifidEn, idexEn, exmemEn, memwbEn;
  logic             ifidFl, idexFl, exmemFl, memwbFl;
  logic             hzErr;
  logic [CW-1:0]    stallCycles, flushEvents;

  typedef struct {
    logic [8:0]    ctrl;
    logic          err;
    logic [CW-1:0] stall;
    logic [CW-1:0] flush;
  } exp_t;

  exp_t expQ[$];

  int checks = 0;
  int passed = 0;

  // Reference model state: sticky error, length of the current memory-stall run,
  // and the two event counts.
  bit modelErr   = 1'b0;
  int stallRun   = 0;
  int stallCount = 0;
  int flushCount = 0;

  pipeline_hazard_ctrl #(
    .ASIZE       (ASIZE),
    .MEM_TIMEOUT (TIMEOUT),
    .CNT_W       (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs_addr_i   (idRs),
    .id_rt_addr_i   (idRt),
    .id_uses_rs_i   (useRs),
    .id_uses_rt_i   (useRt),
    .ex_waddr_i     (exWaddr),
    .ex_wen_i       (exWen),
    .ex_memtoreg_i  (exM2r),
    .ex_redirect_i  (exRedir),
    .mem_req_i      (memReq),
    .mem_ready_i    (memRdy),
    .pc_en_o        (pcEn),
    .ifid_en_o      (ifidEn),
    .idex_en_o      (idexEn),
    .exmem_en_o     (exmemEn),
    .memwb_en_o     (memwbEn),
    .ifid_flush_o   (ifidFl),
    .idex_flush_o   (idexFl),
    .exmem_flush_o  (exmemFl),
    .memwb_flush_o  (memwbFl),
    .hz_err_o       (hzErr),
    .stall_cycles_o (stallCycles),
    .flush_events_o (flushEvents)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs just after the edge, predict the outputs for that
  // cycle, and advance the model to what the next edge will leave behind.
  task automatic applyStimulus(input logic r, input logic [ASIZE-1:0] rs, input logic [ASIZE-1:0] rt,
                               input logic urs, input logic urt, input logic [ASIZE-1:0] wa,
                               input logic wen, input logic m2r, input logic redir,
                               input logic req, input logic rdy);
    exp_t e;
    logic [8:0] c;
    bit memHold, hazard;
    @(posedge clk);
    #1;
    rst = r; idRs = rs; idRt = rt; useRs = urs; useRt = urt;
    exWaddr = wa; exWen = wen; exM2r = m2r; exRedir = redir; memReq = req; memRdy = rdy;

    memHold = req && !rdy;
    hazard  = m2r && wen && (wa != 0) && ((urs && rs == wa) || (urt && rt == wa));
    // Order: {pc,ifid,idex,exmem,memwb en, ifid,idex,exmem,memwb flush}
    if (r)             c = 9'b00000_1111;
    else if (modelErr) c = 9'b00000_0000;
    else if (memHold)  c = 9'b00001_0001;
    else if (redir)    c = 9'b11111_1100;
    else if (hazard)   c = 9'b00111_0100;
    else               c = 9'b11111_0000;

    e.ctrl  = c;
    e.err   = modelErr;
    e.stall = CW'(stallCount);
    e.flush = CW'(flushCount);
    expQ.push_back(e);

    if (r) begin
      modelErr = 1'b0; stallRun = 0; stallCount = 0; flushCount = 0;
    end else begin
      if (!modelErr && !c[8]) stallCount = (stallCount < CMAX) ? stallCount + 1 : CMAX;
      if (c[3])               flushCount = (flushCount < CMAX) ? flushCount + 1 : CMAX;
      if (!modelErr) begin
        if (memHold) begin
          stallRun++;
          if (stallRun > TIMEOUT) modelErr = 1'b1;
        end else begin
          stallRun = 0;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
  endtask

  // Monitor: every cycle the DUT presents a control vector; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("ctrl",  {23'd0, pcEn, ifidEn, idexEn, exmemEn, memwbEn, ifidFl, idexFl, exmemFl, memwbFl}, {23'd0, e.ctrl});
        checkOutput("hz_err", {31'd0, hzErr}, {31'd0, e.err});
        checkOutput("stall_cycles", {28'd0, stallCycles}, {28'd0, e.stall});
        checkOutput("flush_events", {28'd0, flushEvents}, {28'd0, e.flush});
      end
    end
  end

  // Stimulus: directed scenarios first, then randomized traffic.
  initial begin
    rst = 1'b1; idRs = 0; idRt = 0; useRs = 0; useRt = 0; exWaddr = 0;
    exWen = 0; exM2r = 0; exRedir = 0; memReq = 0; memRdy = 0;
    repeat (2) @(posedge clk);

    // Reset then idle.
    repeat (2) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Load-use on rs, then the load moves on.
    applyStimulus(0, 5, 0, 1, 0, 5, 1, 1, 0, 0, 0);
    idle(1);
    // Load to $0: no hazard.
    applyStimulus(0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0);
    // Load-use on rt; rt match ignored when not used.
    applyStimulus(0, 3, 7, 1, 1, 7, 1, 1, 0, 0, 0);
    applyStimulus(0, 3, 7, 1, 0, 7, 1, 1, 0, 0, 0);
    idle(1);
    // Redirect.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(1);
    // Memory wait of 3 cycles then release.
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);
    // Stall + redirect + load-use together, then release with redirect.
    repeat (2) applyStimulus(0, 4, 0, 1, 0, 4, 1, 1, 1, 1, 0);
    applyStimulus(0, 4, 0, 1, 0, 4, 1, 1, 1, 1, 1);
    idle(1);
    // mem_req dropped while waiting releases the pipeline.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    // Timeout into ERROR, ready ignored, reset recovers.
    repeat (7) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (2) applyStimulus(0, 2, 0, 1, 0, 2, 1, 1, 1, 1, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);
    // Saturate the flush counter.
    repeat (CMAX + 3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 59) == 0),
                    ASIZE'($urandom_range(0, 7)), ASIZE'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ASIZE'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) != 0));
    end

    idle(1);
    repeat (2) @(negedge clk);
    checks++;
    if (expQ.size() == 0) passed++;
    else $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
